// File: rtl/reset_seq_pkg.sv
// Shared types and range limits for the reset sequencer.
package reset_seq_pkg;

  // Largest supported number of reset outputs.
  localparam int MAX_NUM_OUT = 16;
  // Default width of the hold, stagger and debounce counters.
  localparam int DEF_CNT_W = 8;

  // Sequencer states. PRE is only reachable when RESET_SEQ_EDGE_EN is defined.
  typedef enum logic [1:0] {
    PRE     = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset fan-out bundle: the per-domain resets plus sequence status.
// The master side is driven by reset_sequencer; the slave side is read by consumers.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 4
);
  logic [NUM_OUT-1:0] rst_out;
  logic               busy;
  logic               done;

  modport master (output rst_out, output busy, output done);
  modport slave  (input  rst_out, input  busy, input  done);
endinterface

// File: rtl/sync_debounce.sv
// Push-button conditioning: 2-flop synchroniser on every clk, then a
// tick-gated debounce counter that saturates at DEBOUNCE_CYCLES.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic manual_i,
  output logic pressed_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] deb_q;
  logic [CNT_W-1:0] deb_d;

  // Synchroniser and debounce count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
    end else begin
      sync1_q <= manual_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  // Count ticks while the synchronised input is high; any low cycle clears it.
  always_comb begin
    deb_d = deb_q;
    if (!sync2_q) begin
      deb_d = '0;
    end else if (tick_i && (deb_q != CNT_W'(DEBOUNCE_CYCLES))) begin
      deb_d = deb_q + CNT_W'(1);
    end
  end

  assign pressed_o = (deb_q == CNT_W'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the board top level: all outputs assert, then
// release one at a time in index order, timed in tick units.
// Optional feature macro: RESET_SEQ_EDGE_EN (one-tick all-low PRE phase before
// every sequence start, so posedge-reset logic always sees a rising edge).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT         = 4,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGGER_CYCLES  = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              manual,
  reset_sequencer_if.master rst_if
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

`ifdef RESET_SEQ_EDGE_EN
  localparam seq_state_e START_STATE = PRE;
  localparam logic       START_LEVEL = 1'b0;
`else
  localparam seq_state_e START_STATE = ASSERT;
  localparam logic       START_LEVEL = 1'b1;
`endif

  // Reject parameter values the sequencer cannot honour.
  if (NUM_OUT < 1 || NUM_OUT > MAX_NUM_OUT) begin : g_bad_num_out
    $error("reset_sequencer: NUM_OUT must be 1..%0d", MAX_NUM_OUT);
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >=1 and fit in CNT_W bits");
  end
  if (STAGGER_CYCLES < 1 || STAGGER_CYCLES >= (1 << CNT_W)) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER_CYCLES must be >=1 and fit in CNT_W bits");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_debounce
    $error("reset_sequencer: DEBOUNCE_CYCLES must be >=1 and fit in CNT_W bits");
  end

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   stag_q, stag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               pressed_q;
  logic               pressed;
  logic               done_w;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sync_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .manual_i (manual),
    .pressed_o(pressed)
  );

  // State, counters and registered reset outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= START_STATE;
      hold_q    <= '0;
      stag_q    <= '0;
      idx_q     <= '0;
      rst_out_q <= {NUM_OUT{START_LEVEL}};
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      stag_q    <= stag_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      pressed_q <= pressed;
    end
  end

  // Next-state logic: a debounced press overrides everything and restarts the
  // sequence; otherwise hold, then release one output per stagger interval.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stag_d    = stag_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    if (pressed) begin
      hold_d = '0;
      stag_d = '0;
      idx_d  = '0;
`ifdef RESET_SEQ_EDGE_EN
      // A new press passes through PRE for one tick, then parks in ASSERT.
      if (!pressed_q || (state_q == PRE && !tick)) begin
        state_d   = PRE;
        rst_out_d = '0;
      end else begin
        state_d   = ASSERT;
        rst_out_d = '1;
      end
`else
      state_d   = ASSERT;
      rst_out_d = '1;
`endif
    end else begin
      case (state_q)
`ifdef RESET_SEQ_EDGE_EN
        PRE: begin
          rst_out_d = '0;
          if (tick) begin
            state_d   = ASSERT;
            rst_out_d = '1;
          end
        end
`endif
        ASSERT: begin
          rst_out_d = '1;
          if (tick) begin
            if (hold_q == CNT_W'(HOLD_CYCLES - 1)) begin
              hold_d = '0;
              if (NUM_OUT == 1) begin
                state_d   = RUN;
                rst_out_d = '0;
              end else begin
                state_d      = RELEASE;
                rst_out_d[0] = 1'b0;
                idx_d        = IDX_W'(1);
              end
            end else begin
              hold_d = hold_q + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (tick) begin
            if (stag_q == CNT_W'(STAGGER_CYCLES - 1)) begin
              stag_d = '0;
              for (int i = 0; i < NUM_OUT; i++) begin
                if (idx_q == IDX_W'(i)) begin
                  rst_out_d[i] = 1'b0;
                end
              end
              if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                state_d = RUN;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              stag_d = stag_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          rst_out_d = '0;
        end
        default: begin
          state_d   = ASSERT;
          rst_out_d = '1;
        end
      endcase
    end
  end

  assign done_w         = (state_q == RUN);
  assign rst_if.rst_out = rst_out_q;
  assign rst_if.done    = done_w;
  assign rst_if.busy    = ~done_w;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations,
// then randomized tick/manual/rst_n traffic, all checked every cycle against a
// tick-count reference model. Two instances: 4 outputs and 1 output.
module tb_reset_sequencer;

`ifdef RESET_SEQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam int E   = EDGE ? 1 : 0;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic manual;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_OUT(4)) if0 ();
  reset_sequencer_if #(.NUM_OUT(1)) if1 ();

  reset_sequencer #(
    .NUM_OUT(4), .HOLD_CYCLES(4), .STAGGER_CYCLES(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .manual(manual), .rst_if(if0.master)
  );

  reset_sequencer #(
    .NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .manual(manual), .rst_if(if1.master)
  );

  // Reference model: per instance, ticks counted since the sequence started.
  int m_numo [2] = '{4, 1};
  int m_hold [2] = '{4, 1};
  int m_stag [2] = '{2, 2};
  int m_n    [2];
  bit m_pre  [2];
  bit m_s1   [2];
  bit m_s2   [2];
  int m_deb  [2];
  bit m_prevp[2];

  function automatic logic [15:0] exp_rst(int m);
    logic [15:0] v = '0;
    for (int i = 0; i < m_numo[m]; i++)
      v[i] = !m_pre[m] && (m_n[m] < m_hold[m] + i * m_stag[m]);
    return v;
  endfunction

  function automatic bit exp_done(int m);
    return !m_pre[m] && (m_n[m] >= m_hold[m] + (m_numo[m] - 1) * m_stag[m]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          m_n[m] = 0; m_pre[m] = EDGE; m_s1[m] = 0; m_s2[m] = 0;
          m_deb[m] = 0; m_prevp[m] = 0;
        end else begin
          bit p;
          p = (m_deb[m] == DEB);
          if (p) begin
            m_n[m] = 0;
            if (EDGE) begin
              if (!m_prevp[m]) m_pre[m] = 1'b1;
              else if (tick) m_pre[m] = 1'b0;
            end
          end else if (m_pre[m]) begin
            if (tick) m_pre[m] = 1'b0;
          end else if (tick && m_n[m] < 1000) begin
            m_n[m] = m_n[m] + 1;
          end
          m_prevp[m] = p;
          if (!m_s2[m]) m_deb[m] = 0;
          else if (tick && m_deb[m] < DEB) m_deb[m] = m_deb[m] + 1;
          m_s2[m] = m_s1[m];
          m_s1[m] = manual;
        end
      end
    end
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model rst_out[4]", {12'b0, if0.rst_out}, exp_rst(0));
        chk("model done[4]", {15'b0, if0.done}, {15'b0, exp_done(0)});
        chk("model busy[4]", {15'b0, if0.busy}, {15'b0, !exp_done(0)});
        chk("model rst_out[1]", {15'b0, if1.rst_out}, exp_rst(1));
        chk("model done[1]", {15'b0, if1.done}, {15'b0, exp_done(1)});
        chk("model busy[1]", {15'b0, if1.busy}, {15'b0, !exp_done(1)});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic lit4(string name, logic [3:0] r, logic d);
    chk(name, {12'b0, if0.rst_out}, {12'b0, r});
    chk({name, " done"}, {15'b0, if0.done}, {15'b0, d});
    chk({name, " busy"}, {15'b0, if0.busy}, {15'b0, ~d});
  endtask

  initial begin
    int run_left;
    int off;
    rst_n = 1'b0; tick = 1'b0; manual = 1'b0;
    step(); chk_en = 1'b1; step();

    // Scenario 1: tick every cycle after a two-cycle reset.
    lit4("s1 reset", EDGE ? 4'b0000 : 4'b1111, 1'b0);
    chk("s1 reset n1", {15'b0, if1.rst_out}, {15'b0, ~EDGE});
    rst_n = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1 + E) chk("s1 n1 released", {14'b0, if1.rst_out, if1.done}, 16'h0001);
      if (k == E)     chk("s1 n1 held", {14'b0, if1.rst_out, if1.done}, 16'h0002);
      if (k == 3 + E)  lit4("s1 k3", 4'b1111, 1'b0);
      if (k == 4 + E)  lit4("s1 k4", 4'b1110, 1'b0);
      if (k == 6 + E)  lit4("s1 k6", 4'b1100, 1'b0);
      if (k == 8 + E)  lit4("s1 k8", 4'b1000, 1'b0);
      if (k == 9 + E)  lit4("s1 k9", 4'b1000, 1'b0);
      if (k == 10 + E) lit4("s1 k10", 4'b0000, 1'b1);
    end
    $display("scenario 1 (tick every cycle) complete");

    // Scenario 2: tick every 5th cycle.
    rst_n = 1'b0; tick = 1'b0; step(); step();
    rst_n = 1'b1;
    off = 5 * E;
    for (int c = 1; c <= 60; c++) begin
      tick = (c % 5 == 0);
      step();
      if (c == 19 + off) lit4("s2 c19", 4'b1111, 1'b0);
      if (c == 20 + off) lit4("s2 c20", 4'b1110, 1'b0);
      if (c == 30 + off) lit4("s2 c30", 4'b1100, 1'b0);
      if (c == 40 + off) lit4("s2 c40", 4'b1000, 1'b0);
      if (c == 49 + off) lit4("s2 c49", 4'b1000, 1'b0);
      if (c == 50 + off) lit4("s2 c50", 4'b0000, 1'b1);
    end
    $display("scenario 2 (tick every 5th cycle) complete");

    // Scenario 3: manual glitch ignored, long press restarts the sequence.
    tick = 1'b1;
    manual = 1'b1; step(); step();
    manual = 1'b0;
    for (int k = 0; k < 6; k++) step();
    lit4("s3 glitch", 4'b0000, 1'b1);
    manual = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 5) lit4("s3 press k5", 4'b0000, 1'b1);
      if (k == 6) chk("s3 press k6", {12'b0, if0.rst_out}, EDGE ? 16'h0000 : 16'h000f);
      if (k == 7) lit4("s3 press k7", 4'b1111, 1'b0);
    end
    manual = 1'b0;
    for (int k = 0; k < 20; k++) step();
    lit4("s3 after press", 4'b0000, 1'b1);
    $display("scenario 3 (manual press) complete");

    // Scenario 4: one-cycle rst_n pulse mid-release.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < 6 + E; k++) step();
    lit4("s4 mid", 4'b1100, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    lit4("s4 restart", EDGE ? 4'b0000 : 4'b1111, 1'b0);
    for (int k = 0; k < 14; k++) step();
    lit4("s4 end", 4'b0000, 1'b1);
    $display("scenario 4 (rst_n mid-release) complete");

    // Randomized traffic checked by the model.
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if ((c / 250) % 2 == 0) tick = ($urandom_range(0, 2) == 0);
      else tick = 1'b1;
      if (run_left == 0) begin
        manual = ($urandom_range(0, 2) == 0);
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    $display("random phase complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
